// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - master request ports and shared slave bus of mem_arbiter
interface mem_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
);
    localparam int ID_W = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]        HTRANS;
    logic [NUM_MASTERS*ADDR_W-1:0] HADDR;
    logic [NUM_MASTERS-1:0]        HWRITE;
    logic [NUM_MASTERS*DATA_W-1:0] HWDATA;
    logic [ADDR_W-1:0]             PADDR;
    logic                          HWRITE_O;
    logic [DATA_W-1:0]             PDATA;
    logic [NUM_MASTERS-1:0]        grant;
    logic [ID_W-1:0]               grant_id;
    logic [NUM_MASTERS-1:0]        stall;
    logic                          busy;

    // master: the requesting side; slave: the arbiter itself
    modport master (
        output HTRANS, HADDR, HWRITE, HWDATA,
        input  PADDR, HWRITE_O, PDATA, grant, grant_id, stall, busy
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HWDATA,
        output PADDR, HWRITE_O, PDATA, grant, grant_id, stall, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-master shared memory bus arbiter with hold limit
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int RR_MODE     = 0,
    parameter int MAX_HOLD    = 8
) (
    input  logic         CLK,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_MASTERS);
    localparam int HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        last_owner_q, last_owner_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [NUM_MASTERS-1:0] others_req;
    logic [ID_W-1:0]        arb_start;
    logic                   hold_expired;

    // First requester found scanning upward from start, wrapping at NUM_MASTERS.
    function automatic logic [ID_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                             input logic [ID_W-1:0] start);
        logic [ID_W-1:0] win;
        logic            found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            int idx;
            idx = int'(start) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        owner_oh     = NUM_MASTERS'(1) << owner_q;
        others_req   = bus.HTRANS & ~owner_oh;
        if (RR_MODE != 0)
            arb_start = (int'(last_owner_q) == NUM_MASTERS - 1) ? '0 : last_owner_q + 1'b1;
        else
            arb_start = '0;
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && (|others_req);

        case (state_q)
            IDLE: begin
                if (|bus.HTRANS) begin
                    state_d      = OWNED;
                    owner_d      = pick(bus.HTRANS, arb_start);
                    last_owner_d = owner_d;
                    hold_cnt_d   = '0;
                end
            end
            OWNED: begin
                if (bus.HTRANS[owner_q] && !hold_expired) begin
                    // Counter saturates so the unlimited-hold build never wraps.
                    if ((|others_req) && (hold_cnt_q != {HOLD_W{1'b1}}))
                        hold_cnt_d = hold_cnt_q + 1'b1;
                end else if (|others_req) begin
                    owner_d      = pick(others_req, arb_start);
                    last_owner_d = owner_d;
                    hold_cnt_d   = '0;
                end else begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.grant    = '0;
        bus.grant_id = '0;
        bus.PADDR    = '0;
        bus.PDATA    = '0;
        bus.HWRITE_O = 1'b0;
        bus.busy     = 1'b0;
        if (state_q == OWNED) begin
            bus.grant    = NUM_MASTERS'(1) << owner_q;
            bus.grant_id = owner_q;
            bus.PADDR    = bus.HADDR[int'(owner_q)*ADDR_W +: ADDR_W];
            bus.PDATA    = bus.HWDATA[int'(owner_q)*DATA_W +: DATA_W];
            bus.HWRITE_O = bus.HTRANS[owner_q] & bus.HWRITE[owner_q];
            bus.busy     = 1'b1;
        end
        bus.stall = bus.HTRANS & ~bus.grant;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    mem_arbiter_if #(.NUM_MASTERS(2)) ifa ();
    mem_arbiter_if #(.NUM_MASTERS(4)) ifb ();
    mem_arbiter_if #(.NUM_MASTERS(4)) ifc ();

    mem_arbiter #(.NUM_MASTERS(2), .RR_MODE(0), .MAX_HOLD(4)) dut_a (
        .CLK(clk), .reset(reset), .bus(ifa)
    );
    mem_arbiter #(.NUM_MASTERS(4), .RR_MODE(0), .MAX_HOLD(0)) dut_b (
        .CLK(clk), .reset(reset), .bus(ifb)
    );
    mem_arbiter #(.NUM_MASTERS(4), .RR_MODE(1), .MAX_HOLD(1)) dut_c (
        .CLK(clk), .reset(reset), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_exp [4];
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        ifa.HTRANS = '0; ifa.HADDR = '0; ifa.HWRITE = '0; ifa.HWDATA = '0;
        ifb.HTRANS = '0; ifb.HADDR = '0; ifb.HWRITE = '0; ifb.HWDATA = '0;
        ifc.HTRANS = '0; ifc.HADDR = '0; ifc.HWRITE = '0; ifc.HWDATA = '0;

        // reset held two cycles with both masters requesting
        ifa.HTRANS = 2'b11;
        ifa.HADDR  = {64'h40, 64'h100};
        next_cycle();
        next_cycle();
        check("rst_grant", ifa.grant, 2'b00);
        check("rst_busy", ifa.busy, 1'b0);
        check("rst_paddr", ifa.PADDR, 64'h0);
        check("rst_stall", ifa.stall, 2'b11);
        check("rst_gid", ifa.grant_id, 0);

        reset = 1'b0;
        next_cycle();
        check("post_rst_grant", ifa.grant, 2'b01);
        check("post_rst_stall", ifa.stall, 2'b10);

        ifa.HTRANS = 2'b00;
        next_cycle();
        check("idle_grant", ifa.grant, 2'b00);

        // single request from master 1 at 0x40
        ifa.HTRANS = 2'b10;
        #1;
        check("single_stall_req", ifa.stall, 2'b10);
        next_cycle();
        check("single_grant", ifa.grant, 2'b10);
        check("single_gid", ifa.grant_id, 1);
        check("single_paddr", ifa.PADDR, 64'h40);
        check("single_stall", ifa.stall, 2'b00);

        // owner drops, master 0 takes over with no idle bubble
        ifa.HTRANS = 2'b01;
        next_cycle();
        check("handover_grant", ifa.grant, 2'b01);
        check("handover_paddr", ifa.PADDR, 64'h100);
        next_cycle();
        next_cycle();
        check("alone_grant", ifa.grant, 2'b01);
        check("alone_hold", dut_a.hold_cnt_q, 0);

        // master 1 waits from cycle K; preempted at end of K+3
        ifa.HTRANS = 2'b11;
        #1;
        check("hold_stall_k", ifa.stall, 2'b10);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            check("hold_keep", ifa.grant, 2'b01);
        end
        check("hold_cnt_k3", dut_a.hold_cnt_q, 3);
        next_cycle();
        check("preempt_grant", ifa.grant, 2'b10);
        check("preempt_hold", dut_a.hold_cnt_q, 0);
        check("preempt_stall", ifa.stall, 2'b01);

        // write path: owner master 1 writes, stalled master 0 must not leak
        ifa.HWRITE = 2'b11;
        ifa.HWDATA = {64'hDEADBEEF, 64'h1234};
        #1;
        check("wr_strobe", ifa.HWRITE_O, 1'b1);
        check("wr_data", ifa.PDATA, 64'hDEADBEEF);
        ifa.HTRANS = 2'b01;
        ifa.HWRITE = 2'b10;
        #1;
        check("wr_owner_dropped", ifa.HWRITE_O, 1'b0);
        next_cycle();
        check("wr_new_owner", ifa.grant, 2'b01);
        check("wr_nonowner_leak", ifa.HWRITE_O, 1'b0);
        check("wr_new_pdata", ifa.PDATA, 64'h1234);
        ifa.HTRANS = 2'b00;
        next_cycle();
        check("end_busy", ifa.busy, 1'b0);
        check("end_pdata", ifa.PDATA, 64'h0);

        // fixed priority, four masters
        ifb.HTRANS = 4'b1100;
        #1;
        check("fp_stall", ifb.stall, 4'b1100);
        next_cycle();
        check("fp_grant", ifb.grant, 4'b0100);
        check("fp_gid", ifb.grant_id, 2);
        next_cycle();
        next_cycle();
        check("fp_unlimited", ifb.grant, 4'b0100);
        ifb.HTRANS = 4'b1000;
        next_cycle();
        check("fp_handover", ifb.grant, 4'b1000);
        check("fp_handover_gid", ifb.grant_id, 3);
        ifb.HTRANS = 4'b1011;
        next_cycle();
        check("fp_owner_kept", ifb.grant, 4'b1000);
        ifb.HTRANS = 4'b0011;
        next_cycle();
        check("fp_lowest", ifb.grant, 4'b0001);
        ifb.HTRANS = 4'b0000;

        // round robin with one-cycle hold
        ifc.HTRANS = 4'b0001;
        next_cycle();
        check("rr_first", ifc.grant_id, 0);
        ifc.HTRANS = 4'b1111;
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("rr_seq", ifc.grant, rr_exp[i]);
        end

        // reset drops ownership mid-flight
        reset = 1'b1;
        next_cycle();
        check("rr_rst_grant", ifc.grant, 4'b0000);
        check("rr_rst_stall", ifc.stall, 4'b1111);
        reset = 1'b0;
        ifc.HTRANS = 4'b0000;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
